// File: rtl/io_uart_pkg.sv
// Shared definitions for the io_uart register window and its serial state machines.
package io_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_VALID     = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_RX_FRAME_ERR = 4;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/io_uart_if.sv
// IO bus port group between the core's IO initiator and a memory-mapped responder.
interface io_uart_if;
  logic [31:0] io_address;
  logic [31:0] io_write_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_read_value;

  modport master (output io_address, io_write_value, io_write_en, io_read_en,
                  input  io_read_value);
  modport slave  (input  io_address, io_write_value, io_write_en, io_read_en,
                  output io_read_value);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle byte_done/frame_err pulses.
module uart_rx_core
  import io_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic [15:0] div,
  output logic        byte_done,
  output logic [7:0]  rx_byte,
  output logic        frame_err
);
  logic [1:0]  sync_q;
  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;

  assign rx_s    = sync_q[1];
  assign rx_byte = sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= MIN_DIV;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    div_d     = div_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          div_d   = div;
        end
      end
      // Half-bit wait re-checks the start bit so short glitches are rejected.
      START: if (cnt_q == (div_q >> 1) - 16'd1) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == div_q - 16'd1) begin
        cnt_d = '0;
        sh_d  = {rx_s, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == div_q - 16'd1) begin
        cnt_d     = '0;
        state_d   = IDLE;
        byte_done = rx_s;
        frame_err = !rx_s;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/io_uart.sv
// Memory-mapped UART on the core IO bus: register decode, 4-deep TX FIFO, 8N1 transmitter, RX flags.
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned DIVISOR   = 16,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  io_uart_if.slave io,
  output logic     uart_tx,
  input  logic     uart_rx
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  logic       sel, wr, rd, rd_data, push, pop, fifo_full, fifo_empty, tx_empty;
  logic [1:0] reg_sel;
  logic       unused_bits;

  assign sel         = io.io_address[31:4] == BASE_ADDR[31:4];
  assign reg_sel     = io.io_address[3:2];
  assign wr          = io.io_write_en && sel;
  assign rd          = io.io_read_en && sel;
  assign rd_data     = rd && reg_sel == REG_DATA;
  assign unused_bits = ^{io.io_address[1:0], io.io_write_value[31:16]};

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q;

  // Full is judged before any same-cycle pop, so a store to a full FIFO is always lost.
  assign fifo_full  = fifo_cnt_q == CW'(TX_DEPTH);
  assign fifo_empty = fifo_cnt_q == '0;
  assign push       = wr && reg_sel == REG_DATA && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= io.io_write_value[7:0];
  end

  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d, div_q;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_tick;

  assign tx_empty = fifo_empty && tx_state_q == IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= 16'(DIVISOR);
      tx_bit_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  always_ff @(posedge clk) tx_sh_q <= tx_sh_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    pop        = 1'b0;
    uart_tx    = 1'b1;
    tx_tick    = tx_cnt_q == tx_div_q - 16'd1;
    if (tx_state_q != IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 16'd1;
    case (tx_state_q)
      IDLE: if (!fifo_empty) begin
        pop        = 1'b1;
        tx_sh_d    = fifo_mem[rd_ptr_q];
        tx_div_d   = div_q;
        tx_cnt_d   = '0;
        tx_state_d = START;
      end
      START: begin
        uart_tx = 1'b0;
        if (tx_tick) begin
          tx_bit_d   = '0;
          tx_state_d = DATA;
        end
      end
      DATA: begin
        uart_tx = tx_sh_q[0];
        if (tx_tick) begin
          tx_sh_d  = tx_sh_q >> 1;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = STOP;
        end
      end
      // Chaining straight into START keeps back-to-back frames gap-free.
      STOP: if (tx_tick) begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_sh_d    = fifo_mem[rd_ptr_q];
          tx_div_d   = div_q;
          tx_state_d = START;
        end else begin
          tx_state_d = IDLE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  logic [7:0] rx_byte, rx_data_q;
  logic       rx_done, rx_ferr, rx_valid_q, rx_overrun_q, rx_frame_err_q, st_wr;

  uart_rx_core u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (uart_rx),
    .div       (div_q),
    .byte_done (rx_done),
    .rx_byte   (rx_byte),
    .frame_err (rx_ferr)
  );

  assign st_wr = wr && reg_sel == REG_STATUS;

  // A byte landing on the same edge as a DATA read wins and is not an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q          <= 16'(DIVISOR);
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      if (wr && reg_sel == REG_DIV) div_q <= clamp_div(io.io_write_value[15:0]);
      if (rx_done) begin
        rx_data_q  <= rx_byte;
        rx_valid_q <= 1'b1;
      end else if (rd_data) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_done && rx_valid_q && !rd_data) rx_overrun_q <= 1'b1;
      else if (st_wr && io.io_write_value[ST_RX_OVERRUN]) rx_overrun_q <= 1'b0;
      if (rx_ferr) rx_frame_err_q <= 1'b1;
      else if (st_wr && io.io_write_value[ST_RX_FRAME_ERR]) rx_frame_err_q <= 1'b0;
    end
  end

  always_comb begin
    io.io_read_value = '0;
    if (rd) begin
      case (reg_sel)
        REG_DATA:   io.io_read_value[7:0] = rx_data_q;
        REG_STATUS: begin
          io.io_read_value[ST_TX_FULL]      = fifo_full;
          io.io_read_value[ST_TX_EMPTY]     = tx_empty;
          io.io_read_value[ST_RX_VALID]     = rx_valid_q;
          io.io_read_value[ST_RX_OVERRUN]   = rx_overrun_q;
          io.io_read_value[ST_RX_FRAME_ERR] = rx_frame_err_q;
        end
        REG_DIV:    io.io_read_value[15:0] = div_q;
        default:    io.io_read_value = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_io_uart.sv
// Directed bench for io_uart: register table, TX frame timing, FIFO full, RX flags, async reset.
module tb_io_uart;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  io_uart_if bus();

  io_uart #(.BASE_ADDR(32'h0000_1000), .DIVISOR(16), .TX_DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io      (bus),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.io_address     = a;
    bus.io_write_value = d;
    bus.io_write_en    = 1'b1;
    @(posedge clk);
    #1 bus.io_write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.io_address = a;
    bus.io_read_en = 1'b1;
    #1 d = bus.io_read_value;
    @(posedge clk);
    #1 bus.io_read_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      tick(16);
    end
    uart_rx = 1'b1;
  endtask

  // Independent serial decoder on uart_tx, sampling each bit at its centre.
  logic [7:0] mon_bytes[$];
  int         mon_starts[$];
  initial begin : monitor
    int         s;
    logic [7:0] b;
    logic       good;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        s = cyc;
        tick(8);
        good = (uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          tick(16);
          b[i] = uart_tx;
        end
        tick(16);
        if (good && uart_tx === 1'b1) begin
          mon_bytes.push_back(b);
          mon_starts.push_back(s);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t        vecs[$];
    logic [31:0] d;
    logic [7:0]  a5;
    int          lows;
    logic [7:0]  six [6];

    bus.io_address     = '0;
    bus.io_write_value = '0;
    bus.io_write_en    = 1'b0;
    bus.io_read_en     = 1'b0;

    tick(3);
    check("tx in reset", 32'(uart_tx), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    bus.io_address = 32'h1004;
    #1 check("no read -> 0", bus.io_read_value, 32'h0);

    vecs.push_back('{1'b0, 32'h0000_1004, 32'h0,         32'h2});
    vecs.push_back('{1'b0, 32'h0000_2000, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 32'h0000_1010, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 32'h0000_1008, 32'h0,         32'd16});
    vecs.push_back('{1'b0, 32'h0000_100C, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 32'h0000_1006, 32'h0,         32'h2});
    vecs.push_back('{1'b1, 32'h0000_1008, 32'h2,         32'h0});
    vecs.push_back('{1'b0, 32'h0000_1008, 32'h0,         32'h4});
    vecs.push_back('{1'b1, 32'h0000_1008, 32'h0001_0009, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_1008, 32'h0,         32'h9});
    vecs.push_back('{1'b1, 32'h0000_100C, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_100C, 32'h0,         32'h0});
    vecs.push_back('{1'b1, 32'h0000_1004, 32'h0000_001F, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_1004, 32'h0,         32'h2});
    vecs.push_back('{1'b1, 32'h0000_1008, 32'd16,        32'h0});
    vecs.push_back('{1'b0, 32'h0000_1008, 32'h0,         32'd16});
    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else read_check($sformatf("vec%0d rd 0x%0h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end

    // Single 0xA5 frame, cycle-exact against the store edge N.
    a5 = 8'hA5;
    bus_write(32'h1000, 32'hA5);
    check("a5 tx at N", 32'(uart_tx), 32'h1);
    tick(1);
    check("a5 start at N+1", 32'(uart_tx), 32'h0);
    tick(15);
    check("a5 start at N+16", 32'(uart_tx), 32'h0);
    tick(1);
    check("a5 bit0 at N+17", 32'(uart_tx), 32'h1);
    tick(8);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick(16);
      check($sformatf("a5 bit%0d", i), 32'(uart_tx), 32'(a5[i]));
    end
    tick(16);
    check("a5 stop", 32'(uart_tx), 32'h1);
    tick(7);
    read_check("a5 busy at N+160", 32'h1004, 32'h0);
    read_check("a5 idle at N+161", 32'h1004, 32'h2);
    check("a5 monitor count", 32'(mon_bytes.size()), 32'd1);
    mon_bytes.delete();
    mon_starts.delete();

    // Six stores into a 4-deep FIFO with one entry already popped.
    six = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    for (int i = 0; i < 4; i++) bus_write(32'h1000, 32'(six[i]));
    read_check("fifo 3 queued", 32'h1004, 32'h0);
    bus_write(32'h1000, 32'(six[4]));
    read_check("fifo full after 5th", 32'h1004, 32'h1);
    bus_write(32'h1000, 32'(six[5]));
    read_check("fifo full after 6th", 32'h1004, 32'h1);
    tick(5 * 160 + 300);
    check("frame count", 32'(mon_bytes.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < mon_bytes.size()) begin
        check($sformatf("frame%0d byte", i), 32'(mon_bytes[i]), 32'(six[i]));
        if (i > 0) check($sformatf("frame%0d gap", i), 32'(mon_starts[i] - mon_starts[i-1]), 32'd160);
      end
    end
    read_check("tx drained", 32'h1004, 32'h2);

    // Receive path.
    send_rx(8'h3C, 1'b1);
    tick(10);
    read_check("rx valid", 32'h1004, 32'h6);
    read_check("rx data 3c", 32'h1000, 32'h3C);
    read_check("rx valid cleared", 32'h1004, 32'h2);

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    tick(10);
    read_check("overrun status", 32'h1004, 32'hE);
    bus_write(32'h1004, 32'h8);
    read_check("overrun cleared", 32'h1004, 32'h6);
    read_check("overrun data 22", 32'h1000, 32'h22);
    read_check("after data read", 32'h1004, 32'h2);

    send_rx(8'h55, 1'b1);
    tick(10);
    read_check("rx 55 valid", 32'h1004, 32'h6);
    send_rx(8'hAA, 1'b0);
    tick(30);
    read_check("frame err status", 32'h1004, 32'h16);
    read_check("frame err keeps data", 32'h1000, 32'h55);
    bus_write(32'h1004, 32'h10);
    read_check("frame err cleared", 32'h1004, 32'h2);

    // Asynchronous reset in the middle of a frame with queued bytes.
    bus_write(32'h1008, 32'd20);
    for (int i = 0; i < 3; i++) bus_write(32'h1000, 32'h0);
    tick(50);
    check("tx low mid-frame", 32'(uart_tx), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("tx high on async reset", 32'(uart_tx), 32'h1);
    read_check("status in reset", 32'h1004, 32'h2);
    read_check("div in reset", 32'h1008, 32'd16);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (uart_tx !== 1'b1) lows++;
    end
    check("no frames after reset", 32'(lows), 32'd0);
    read_check("status after reset", 32'h1004, 32'h2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
